// File: rtl/uart_tx_bridge.sv
// Byte FIFO feeding an 8N1 serializer. UART_TX_ready provides backpressure
// so the producer stalls while the FIFO is full.
module uart_tx_bridge #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [7:0]                    UART_TX,
  input  logic                          UART_TX_valid,
  output logic                          UART_TX_ready,
  output logic                          TXD,
  output logic                          TX_BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            txd_q, txd_d;
  logic            push, pop, cnt_wrap;

  // No push-through when full: ready depends only on the registered count.
  assign UART_TX_ready = ~RESET & (count_q != CNTW'(FIFO_DEPTH));
  assign push          = UART_TX_valid & UART_TX_ready;
  assign cnt_wrap      = (cnt_q == CW'(CLKS_PER_BIT - 1));

  assign TXD        = txd_q;
  assign FIFO_COUNT = count_q;
  assign TX_BUSY    = (state_q != S_IDLE) | (count_q != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    if (state_q != S_IDLE) cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          cnt_d   = '0;
          txd_d   = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_wrap) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          txd_d   = shift_q[0];
        end
      end
      S_DATA: begin
        if (cnt_wrap) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            txd_d   = shift_q[1];
          end
        end
      end
      S_STOP: begin
        txd_d = 1'b1;
        if (cnt_wrap) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= UART_TX;
  end

endmodule
